timer: RTL and testbench
========================

Name: timer

Overview:
- Three-digit BCD countdown timer (M:SS) for the microwave controller.
- While loading, the user keys digits in serially. Once loading ends, the timer counts down to 0:00 at a programmable tick rate, then holds there.
- Outputs the digits to the display decoder and a zero flag to the control FSM.

Parameters:
- TICKS_PER_SEC, 1, number of enabled clock cycles per one-second decrement; minimum 1.
- CNT_W, 32, width of the internal prescaler counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clrn  input  1  synchronous reset, active-high; the name is kept for codebase consistency.
- loadn  input  1  load mode when 0; run mode when 1.
- en  input  1  count enable in run mode.
- data  input  4  BCD digit keyed in during load mode.
- sec_ones  output  4  seconds units digit, BCD.
- sec_tens  output  4  seconds tens digit, BCD.
- mins  output  4  minutes digit, BCD.
- zero  output  1  1 when all three digits are 0.
- tc  output  1  terminal-count pulse.

Behaviour:
- Priority per rising edge: clrn > load (loadn=0) > count (loadn=1 & en=1) > hold.
- Reset (clrn=1):
  - sec_ones, sec_tens and mins go to 0.
  - Prescaler goes to 0.
  - tc goes to 0; zero reads 1.
- Load (loadn=0):
  - If data ≤ 9: shift left one digit. mins <= sec_tens, sec_tens <= sec_ones, sec_ones <= data.
  - If data > 9 or X/Z: no shift, digits hold.
  - Prescaler clears to 0; tc is 0.
  - Keying 9 then 8 yields 0:98. Digit values are stored as entered, including sec_tens > 5.
- Count (loadn=1, en=1, not zero):
  - Prescaler increments each cycle. When it reaches TICKS_PER_SEC-1, it wraps to 0 and the time decrements by one second.
  - With TICKS_PER_SEC=1, the time decrements every enabled cycle.
- Decrement rules:
  - sec_ones>0: sec_ones-1.
  - sec_ones=0 and sec_tens>0: sec_ones=9, sec_tens-1.
  - sec_ones=0, sec_tens=0, mins>0: sec_ones=9, sec_tens=5, mins-1.
- Zero condition: at 0:00 no decrement occurs, digits hold (no wrap to 9:59), and the prescaler holds at 0.
- en=0 in run mode: digits and prescaler hold.
- zero: combinational, (sec_ones==0 && sec_tens==0 && mins==0). It is valid during reset and load.
- tc: registered, one-cycle pulse. Asserted on the cycle after the edge on which a decrement produced 0:00 in run mode; otherwise 0. Loading 0:00 or resetting does not pulse tc.
- Digit outputs are registered and change only on clock edges.
- Load mid-count: takes effect at the next edge, and shifting starts from the current displayed value.
- clrn during load or count clears on the next edge.

Test Plan:
- Reset: clrn=1 for 1 cycle -> digits 0/0/0, zero=1, tc=0.
- Serial load: loadn=0; data=X for 1 cycle, then 9, then 8; loadn=1, en=1, TICKS_PER_SEC=1.
  - After the load edges: mins=0, sec_tens=9, sec_ones=8; the X cycle causes no shift.
  - Count: 98, 97, ..., 90, 89, ..., 00, one per cycle. Reaches 0:00 after exactly 98 enabled cycles, zero=1, tc pulses once, and digits then hold at 0.
- Minute borrow: load 1,0,0 (1:00), run -> next value 0:59, then 0:58.
- Enable gating: 0:05 running, drop en for 3 cycles -> value frozen; resume -> continues from the frozen value.
- Prescaler: TICKS_PER_SEC=4, load 0:03 -> decrements every 4 cycles; zero after 12 enabled cycles.
- Reset mid-count: clrn=1 at 0:42 -> 0:00 next edge, no tc pulse; a subsequent run with en=1 stays at 0:00.

Source files
------------

// File: rtl/timer.sv
// Three-digit BCD countdown timer (M:SS). Digits are keyed in serially while
// loadn is low, then counted down to 0:00 at TICKS_PER_SEC enabled cycles per
// second. The count holds at 0:00 and emits a one-cycle tc pulse on arrival.
module timer #(
    parameter int TICKS_PER_SEC = 1,
    parameter int CNT_W         = 32
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       loadn,
    input  logic       en,
    input  logic [3:0] data,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] mins,
    output logic       zero,
    output logic       tc
);

    localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(TICKS_PER_SEC - 1);

    logic [CNT_W-1:0] presc;
    logic             run;
    logic             tick;
    logic [3:0]       dec_ones;
    logic [3:0]       dec_tens;
    logic [3:0]       dec_mins;
    logic             dec_zero;

    assign zero = (sec_ones == 4'd0) && (sec_tens == 4'd0) && (mins == 4'd0);

    // Counting stops by itself at 0:00, so no wrap to 9:59 is possible.
    assign run  = loadn && en && !zero;
    assign tick = run && (presc == PRESC_LAST);

    // One-second BCD decrement with borrow from tens, then from minutes.
    always_comb begin
        dec_ones = sec_ones;
        dec_tens = sec_tens;
        dec_mins = mins;
        if (sec_ones != 4'd0) begin
            dec_ones = sec_ones - 4'd1;
        end else if (sec_tens != 4'd0) begin
            dec_ones = 4'd9;
            dec_tens = sec_tens - 4'd1;
        end else if (mins != 4'd0) begin
            dec_ones = 4'd9;
            dec_tens = 4'd5;
            dec_mins = mins - 4'd1;
        end
        dec_zero = (dec_ones == 4'd0) && (dec_tens == 4'd0) && (dec_mins == 4'd0);
    end

    // Digit, prescaler and terminal-count registers: reset > load > count > hold.
    always_ff @(posedge clk) begin
        if (clrn) begin
            sec_ones <= 4'd0;
            sec_tens <= 4'd0;
            mins     <= 4'd0;
            presc    <= '0;
            tc       <= 1'b0;
        end else if (!loadn) begin
            presc <= '0;
            tc    <= 1'b0;
            // Non-BCD (or unknown) keys are ignored; the comparison is false for X.
            if (data <= 4'd9) begin
                mins     <= sec_tens;
                sec_tens <= sec_ones;
                sec_ones <= data;
            end
        end else if (run) begin
            tc <= tick && dec_zero;
            if (tick) begin
                presc    <= '0;
                sec_ones <= dec_ones;
                sec_tens <= dec_tens;
                mins     <= dec_mins;
            end else begin
                presc <= presc + 1'b1;
            end
        end else begin
            tc <= 1'b0;
        end
    end

endmodule

// File: tb/tb_timer.sv
// Randomized and directed bench for timer. Two instances (1 and 4 ticks per
// second) share stimulus and are compared each cycle against a model that
// keeps the time as a minutes value plus a two-digit seconds number.
module tb_timer;

    logic       clk = 1'b0;
    logic       clrn, loadn, en;
    logic [3:0] data;
    logic [3:0] so1, st1, mi1, so4, st4, mi4;
    logic       z1, z4, tc1, tc4;

    int errs   = 0;
    int checks = 0;
    int tcs1   = 0;
    int tcs4   = 0;

    int m_min[2];
    int m_sec[2];
    int m_pc[2];
    int m_tc[2];
    int tps[2] = '{1, 4};

    always #5 clk = ~clk;

    timer #(.TICKS_PER_SEC(1)) u_t1 (
        .clk(clk), .clrn(clrn), .loadn(loadn), .en(en), .data(data),
        .sec_ones(so1), .sec_tens(st1), .mins(mi1), .zero(z1), .tc(tc1)
    );

    timer #(.TICKS_PER_SEC(4), .CNT_W(8)) u_t4 (
        .clk(clk), .clrn(clrn), .loadn(loadn), .en(en), .data(data),
        .sec_ones(so4), .sec_tens(st4), .mins(mi4), .zero(z4), .tc(tc4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour for one edge, from the user-visible rules.
    task automatic mstep(input int i);
        if (clrn) begin
            m_min[i] = 0; m_sec[i] = 0; m_pc[i] = 0; m_tc[i] = 0;
        end else if (!loadn) begin
            m_pc[i] = 0; m_tc[i] = 0;
            if (int'(data) <= 9) begin
                m_min[i] = m_sec[i] / 10;
                m_sec[i] = (m_sec[i] % 10) * 10 + int'(data);
            end
        end else if (en && !(m_min[i] == 0 && m_sec[i] == 0)) begin
            m_pc[i]++;
            m_tc[i] = 0;
            if (m_pc[i] == tps[i]) begin
                m_pc[i] = 0;
                if (m_sec[i] > 0) m_sec[i]--;
                else begin m_min[i]--; m_sec[i] = 59; end
                m_tc[i] = (m_min[i] == 0 && m_sec[i] == 0) ? 1 : 0;
            end
        end else begin
            m_tc[i] = 0;
        end
    endtask

    function automatic logic [11:0] mdig(input int i);
        return 12'(m_min[i] * 256 + (m_sec[i] / 10) * 16 + (m_sec[i] % 10));
    endfunction

    task automatic cycle(input logic c, input logic l, input logic e, input logic [3:0] d);
        clrn = c; loadn = l; en = e; data = d;
        @(posedge clk);
        mstep(0);
        mstep(1);
        #1;
        if (tc1) tcs1++;
        if (tc4) tcs4++;
        chk("t1.dig",  {mi1, st1, so1}, mdig(0));
        chk("t1.zero", z1, (m_min[0] == 0 && m_sec[0] == 0) ? 1 : 0);
        chk("t1.tc",   tc1, m_tc[0]);
        chk("t4.dig",  {mi4, st4, so4}, mdig(1));
        chk("t4.zero", z4, (m_min[1] == 0 && m_sec[1] == 0) ? 1 : 0);
        chk("t4.tc",   tc4, m_tc[1]);
    endtask

    task automatic load(input logic [3:0] d);
        cycle(1'b0, 1'b0, 1'b0, d);
    endtask

    task automatic runc(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b1, 1'b1, 4'd0);
    endtask

    initial begin
        clrn = 1'b1; loadn = 1'b1; en = 1'b0; data = 4'd0;
        for (int i = 0; i < 2; i++) begin
            m_min[i] = 0; m_sec[i] = 0; m_pc[i] = 0; m_tc[i] = 0;
        end

        // Reset state
        cycle(1'b1, 1'b1, 1'b0, 4'd0);
        chk("rst.dig",  {mi1, st1, so1}, 12'h000);
        chk("rst.zero", z1, 1'b1);
        chk("rst.tc",   tc1, 1'b0);

        // Serial load with an invalid key first, then 9, 8
        load(4'hF);
        chk("load.inv", {mi1, st1, so1}, 12'h000);
        load(4'd9);
        load(4'd8);
        chk("load.98", {mi1, st1, so1}, 12'h098);

        // Full countdown at one tick per cycle
        tcs1 = 0;
        runc(97);
        chk("run.97.nz", z1, 1'b0);
        runc(1);
        chk("run.98.z",   z1, 1'b1);
        chk("run.98.tc",  tc1, 1'b1);
        runc(5);
        chk("hold.dig",   {mi1, st1, so1}, 12'h000);
        chk("tc.once",    32'(tcs1), 32'd1);

        // Minute borrow
        load(4'd1); load(4'd0); load(4'd0);
        chk("load.100", {mi1, st1, so1}, 12'h100);
        runc(1);
        chk("borrow.059", {mi1, st1, so1}, 12'h059);
        runc(1);
        chk("borrow.058", {mi1, st1, so1}, 12'h058);

        // Enable gating
        cycle(1'b1, 1'b1, 1'b0, 4'd0);
        load(4'd5);
        runc(1);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 1'b0, 4'd0);
        chk("en.frozen", {mi1, st1, so1}, 12'h004);
        runc(1);
        chk("en.resume", {mi1, st1, so1}, 12'h003);

        // Prescaler of 4
        cycle(1'b1, 1'b1, 1'b0, 4'd0);
        load(4'd3);
        tcs4 = 0;
        runc(3);
        chk("ps.3", {mi4, st4, so4}, 12'h003);
        runc(1);
        chk("ps.4", {mi4, st4, so4}, 12'h002);
        runc(7);
        chk("ps.11.nz", z4, 1'b0);
        runc(1);
        chk("ps.12.z", z4, 1'b1);
        chk("ps.tc",   32'(tcs4), 32'd1);

        // Reset mid-count
        load(4'd4); load(4'd2);
        chk("load.42", {mi1, st1, so1}, 12'h042);
        tcs1 = 0;
        cycle(1'b1, 1'b1, 1'b1, 4'd0);
        chk("mrst.dig", {mi1, st1, so1}, 12'h000);
        runc(3);
        chk("mrst.hold", {mi1, st1, so1}, 12'h000);
        chk("mrst.notc", 32'(tcs1), 32'd0);

        // Random traffic against the model
        for (int k = 0; k < 4000; k++) begin
            cycle(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 9) > 1),
                  ($urandom_range(0, 9) > 1),
                  4'($urandom_range(0, 15)));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
